// File: rtl/rr_burst_sched_pkg.sv
// Shared types, default parameters and helpers for the round-robin burst scheduler.
// Optional watchdog is enabled by defining RR_BURST_SCHED_WATCHDOG_EN.
package rr_burst_sched_pkg;

    localparam int unsigned DEF_N_REQ       = 4;
    localparam int unsigned DEF_LEN_W       = 4;
    localparam int unsigned DEF_WDOG_CYCLES = 16;

    // Widest grant vector the onehot helper can build
    localparam int unsigned MAX_REQ = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // One-hot vector with bit 'index' set; callers truncate to their width
    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned index);
        logic [MAX_REQ-1:0] v;
        v = '0;
        if (index < MAX_REQ) begin
            v[index[4:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_burst_sched_pick.sv
// Round-robin priority picker: first requester strictly after last_winner, wrapping.
module rr_priority_pick
    import rr_burst_sched_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned IDX_W = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_winner,
    output logic             any_req,
    output logic [IDX_W-1:0] winner
);

    localparam int unsigned DW = 2 * N_REQ;

    logic [DW-1:0]  dbl;
    logic [DW-1:0]  mask;
    logic [DW-1:0]  masked;
    int unsigned    pos;
    logic           found;

    // Two copies of req so the search past last_winner wraps without a modulo
    assign dbl    = {req, req};
    assign mask   = ~((DW'(2) << last_winner) - DW'(1));
    assign masked = dbl & mask;

    // Lowest set bit of the masked double-width vector
    always_comb begin
        pos   = 0;
        found = 1'b0;
        for (int i = 0; i < int'(DW); i++) begin
            if (masked[i] && !found) begin
                found = 1'b1;
                pos   = i;
            end
        end
        any_req = |req;
        winner  = (pos >= N_REQ) ? IDX_W'(pos - N_REQ) : IDX_W'(pos);
    end

endmodule

// File: rtl/round_robin_burst_scheduler.sv
// Round-robin burst scheduler: grants one requester for a whole burst of
// len+1 beats and re-arbitrates back-to-back on the last beat.
// Optional stall watchdog: define RR_BURST_SCHED_WATCHDOG_EN.
module round_robin_burst_scheduler
    import rr_burst_sched_pkg::*;
#(
    parameter int unsigned N_REQ       = DEF_N_REQ,
    parameter int unsigned LEN_W       = DEF_LEN_W,
    parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    input  logic                   res_ready,
    output logic [N_REQ-1:0]       grant,
    output logic                   beat_valid,
    output logic                   beat_last,
    output logic                   busy,
    output logic                   abort
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    // Parameter sanity check at elaboration
    if (N_REQ < 2 || WDOG_CYCLES < 2) begin : g_param_check
        $error("round_robin_burst_scheduler: N_REQ and WDOG_CYCLES must be >= 2");
    end

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [IDX_W-1:0]   lw_q, lw_d;
    logic               beat_valid_q, beat_valid_d;
    logic               beat_last_q, beat_last_d;
    logic               busy_q, busy_d;
    logic               any_req;
    logic [IDX_W-1:0]   winner;
    logic               xfer;
    logic               rearb;

`ifdef RR_BURST_SCHED_WATCHDOG_EN
    localparam int unsigned STALL_W = $clog2(WDOG_CYCLES);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               abort_q, abort_d;
`endif

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req         (req),
        .last_winner (lw_q),
        .any_req     (any_req),
        .winner      (winner)
    );

    assign xfer = (state_q == BURST) && res_ready;

    // Next-state, pointer, length counter and registered-output values
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rem_d   = rem_q;
        lw_d    = lw_q;
        rearb   = 1'b0;
`ifdef RR_BURST_SCHED_WATCHDOG_EN
        stall_d = stall_q;
        abort_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                rearb = 1'b1;
            end
            BURST: begin
                if (xfer) begin
`ifdef RR_BURST_SCHED_WATCHDOG_EN
                    stall_d = '0;
`endif
                    if (rem_q == '0) begin
                        rearb = 1'b1;
                    end else begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                end
`ifdef RR_BURST_SCHED_WATCHDOG_EN
                else if (stall_q == STALL_W'(WDOG_CYCLES - 1)) begin
                    abort_d = 1'b1;
                    rearb   = 1'b1;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Arbitration point: idle cycle, last beat, or watchdog termination
        if (rearb) begin
            if (any_req) begin
                state_d = BURST;
                grant_d = N_REQ'(onehot(32'(winner)));
                lw_d    = winner;
                rem_d   = req_len[32'(winner) * LEN_W +: LEN_W];
`ifdef RR_BURST_SCHED_WATCHDOG_EN
                stall_d = '0;
`endif
            end else begin
                state_d = IDLE;
                grant_d = '0;
                rem_d   = '0;
            end
        end

        beat_valid_d = (state_d == BURST);
        beat_last_d  = beat_valid_d && (rem_d == '0);
        busy_d       = |grant_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rem_q        <= '0;
            lw_q         <= IDX_W'(N_REQ - 1);
            beat_valid_q <= 1'b0;
            beat_last_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rem_q        <= rem_d;
            lw_q         <= lw_d;
            beat_valid_q <= beat_valid_d;
            beat_last_q  <= beat_last_d;
            busy_q       <= busy_d;
        end
    end

`ifdef RR_BURST_SCHED_WATCHDOG_EN
    // Stall counter and abort pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            abort_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            abort_q <= abort_d;
        end
    end

    assign abort = abort_q;
`else
    assign abort = 1'b0;
`endif

    assign grant      = grant_q;
    assign beat_valid = beat_valid_q;
    assign beat_last  = beat_last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_round_robin_burst_scheduler.sv
// Directed bench for round_robin_burst_scheduler (default build, watchdog off).
module tb_round_robin_burst_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic        res_ready;
    logic [3:0]  grant;
    logic        beat_valid;
    logic        beat_last;
    logic        busy;
    logic        abort;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] len;
        logic        rdy;
        logic [3:0]  grant;
        logic        valid;
        logic        last;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    round_robin_burst_scheduler #(
        .N_REQ       (4),
        .LEN_W       (4),
        .WDOG_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_len    (req_len),
        .res_ready  (res_ready),
        .grant      (grant),
        .beat_valid (beat_valid),
        .beat_last  (beat_last),
        .busy       (busy),
        .abort      (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [15:0] ln, input logic rd,
                       input logic [3:0] g, input logic v, input logic l, input logic b);
        vec_t t;
        t.rst = r; t.req = rq; t.len = ln; t.rdy = rd;
        t.grant = g; t.valid = v; t.last = l; t.busy = b;
        vecs.push_back(t);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_len = '0; res_ready = 1'b1;

        // Single requester, 3-beat burst, then idle
        add(1, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 16'h0002, 1, 4'b0001, 1, 0, 1);
        add(0, 4'b0000, 16'h0002, 1, 4'b0001, 1, 0, 1);
        add(0, 4'b0000, 16'h0002, 1, 4'b0001, 1, 1, 1);
        add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0);
        // All requesting, single-beat bursts rotate with no gap
        add(1, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 16'h0000, 1, 4'b0001, 1, 1, 1);
        add(0, 4'b1111, 16'h0000, 1, 4'b0010, 1, 1, 1);
        add(0, 4'b1111, 16'h0000, 1, 4'b0100, 1, 1, 1);
        add(0, 4'b1111, 16'h0000, 1, 4'b1000, 1, 1, 1);
        add(0, 4'b1111, 16'h0000, 1, 4'b0001, 1, 1, 1);
        add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0);
        // Ready toggling 1,0,1,1: owner 0 two beats, then owner 2 one beat
        add(1, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0101, 16'h0001, 1, 4'b0001, 1, 0, 1);
        add(0, 4'b0101, 16'h0001, 1, 4'b0001, 1, 1, 1);
        add(0, 4'b0101, 16'h0001, 0, 4'b0001, 1, 1, 1);
        add(0, 4'b0101, 16'h0001, 1, 4'b0100, 1, 1, 1);
        add(0, 4'b0000, 16'h0001, 1, 4'b0000, 0, 0, 0);
        // Owner 1 drops req and len changes mid-burst: all 4 beats still issued
        add(0, 4'b0010, 16'h0030, 1, 4'b0010, 1, 0, 1);
        add(0, 4'b0010, 16'h0030, 1, 4'b0010, 1, 0, 1);
        add(0, 4'b0000, 16'h0000, 1, 4'b0010, 1, 0, 1);
        add(0, 4'b0000, 16'h0000, 1, 4'b0010, 1, 1, 1);
        add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0);
        // Reset on beat 2 of a 4-beat burst, then requester 1 wins
        add(0, 4'b0100, 16'h0300, 1, 4'b0100, 1, 0, 1);
        add(0, 4'b0000, 16'h0300, 1, 4'b0100, 1, 0, 1);
        add(1, 4'b0000, 16'h0300, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0010, 16'h0000, 1, 4'b0010, 1, 1, 1);
        add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0);
        // Stall with no watchdog: grant held, then owner 1 follows
        add(0, 4'b0001, 16'h0000, 1, 4'b0001, 1, 1, 1);
        for (int i = 0; i < 4; i++) add(0, 4'b0010, 16'h0000, 0, 4'b0001, 1, 1, 1);
        add(0, 4'b0010, 16'h0000, 1, 4'b0010, 1, 1, 1);
        add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0);
        // Sole requester re-granted back-to-back
        add(0, 4'b0100, 16'h0000, 1, 4'b0100, 1, 1, 1);
        add(0, 4'b0100, 16'h0000, 1, 4'b0100, 1, 1, 1);
        add(0, 4'b0100, 16'h0000, 1, 4'b0100, 1, 1, 1);
        add(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            req       = vecs[i].req;
            req_len   = vecs[i].len;
            res_ready = vecs[i].rdy;
            tick();
            check($sformatf("v%0d grant", i), 16'(grant), 16'(vecs[i].grant));
            check($sformatf("v%0d beat_valid", i), 16'(beat_valid), 16'(vecs[i].valid));
            check($sformatf("v%0d beat_last", i), 16'(beat_last), 16'(vecs[i].last));
            check($sformatf("v%0d busy", i), 16'(busy), 16'(vecs[i].busy));
            check($sformatf("v%0d abort", i), 16'(abort), 16'h0);
        end

        // Fairness with 2-beat bursts: each owner holds 2 cycles, rotation 0..3
        rst = 1'b1; req = '0; req_len = '0; res_ready = 1'b1;
        tick();
        rst = 1'b0; req = 4'b1111; req_len = 16'h1111;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << ((k / 2) % 4);
            tick();
            check($sformatf("fair%0d grant", k), 16'(grant), 16'(exp_g));
            check($sformatf("fair%0d beat_last", k), 16'(beat_last), 16'(k % 2 == 1));
        end

        // Long stall: grant and beat held for 20 cycles, no abort
        rst = 1'b1; req = '0; req_len = '0; res_ready = 1'b1;
        tick();
        rst = 1'b0; req = 4'b0001;
        tick();
        check("stall grant", 16'(grant), 16'h0001);
        req = '0; res_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("stall%0d grant", k), 16'(grant), 16'h0001);
            check($sformatf("stall%0d abort", k), 16'(abort), 16'h0);
        end
        res_ready = 1'b1;
        tick();
        check("stall release busy", 16'(busy), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
